// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, cycle-counter width,
// and the default jump-target table.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int CNT_W     = 16;
  localparam int LUT_DEPTH = 16;
  localparam int JUMP_W    = 12;

  localparam logic [JUMP_W-1:0] JUMP_LUT [LUT_DEPTH] = '{
    12'h000, 12'h080, 12'h300, 12'h123,
    12'h400, 12'h555, 12'h7FF, 12'h800,
    12'h0A0, 12'h0B0, 12'hC00, 12'hD0D,
    12'hE00, 12'hF00, 12'hFFF, 12'h010
  };

endpackage

// File: rtl/fetch_jump_lut.sv
// Combinational jump-target ROM: maps a decode LUT index to an absolute D-bit PC.
// Indices beyond the package table resolve to address 0.
module fetch_jump_lut
  import fetch_pkg::*;
#(
  parameter int D     = 12,
  parameter int LUT_W = 4
) (
  input  logic [LUT_W-1:0] i_idx,
  output logic [D-1:0]     o_target
);

  always_comb begin
    o_target = '0;
    for (int i = 0; i < LUT_DEPTH; i++) begin
      if (int'(i_idx) == i) o_target = D'(JUMP_LUT[i]);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC / fetch sequencer (IDLE/RUN/HALT): one-edge latency from controls to prog_ctr.
// Optional FETCH_CYCLE_CNT_EN adds a saturating RUN-cycle counter output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int D     = 12,
  parameter int OFFW  = 6,
  parameter int LUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [D-1:0]     start_addr,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_taken,
  input  logic [OFFW-1:0]  branch_off,
  input  logic             jump_en,
  input  logic [LUT_W-1:0] jump_idx,
  output logic [D-1:0]     prog_ctr,
  output logic             fetch_valid,
`ifdef FETCH_CYCLE_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
`endif
  output logic             done
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [D-1:0] r_pc;
  logic [D-1:0] w_pc_nxt;
  logic [D-1:0] w_jump_tgt;
  logic [D-1:0] w_branch_sext;
  logic         w_start_acc;

  fetch_jump_lut #(
    .D     (D),
    .LUT_W (LUT_W)
  ) u_jump_lut (
    .i_idx    (jump_idx),
    .o_target (w_jump_tgt)
  );

  assign w_branch_sext = {{(D-OFFW){branch_off[OFFW-1]}}, branch_off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Halt and stall both freeze the PC; a stall swallows any jump/branch seen that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_start_acc = 1'b0;
    case (r_state)
      IDLE, HALT: begin
        if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = start_addr;
          w_start_acc = 1'b1;
        end
      end
      RUN: begin
        if (halt_req) begin
          w_state_nxt = HALT;
        end else if (!stall) begin
          if (jump_en)           w_pc_nxt = w_jump_tgt;
          else if (branch_taken) w_pc_nxt = r_pc + w_branch_sext;
          else                   w_pc_nxt = r_pc + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign prog_ctr    = r_pc;
  assign fetch_valid = (r_state == RUN);
  assign done        = (r_state == HALT);

`ifdef FETCH_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
    end else if (w_start_acc) begin
      r_cycle_cnt <= '0;
    end else if ((r_state == RUN) && (r_cycle_cnt != '1)) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule
